// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: sizing constants and the reorder buffer
// entry record used by the ROB and the execution units.
package ooo_pkg;
   localparam int DEPTH  = 8;
   localparam int TAG_W  = 3;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef struct packed {
      logic              busy;
      logic              done;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] value;
   } rob_entry_t;
endpackage

// File: rtl/rob_entry.sv
// One reorder buffer slot: allocation, result capture from the adder/multiplier
// buses and release on commit.
module rob_entry
   import ooo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_hit,
   input  logic [REG_W-1:0]  alloc_dest,
   input  logic              add_hit,
   input  logic [DATA_W-1:0] add_val,
   input  logic              mul_hit,
   input  logic [DATA_W-1:0] mul_val,
   input  logic              commit_hit,
   output rob_entry_t        entry
);

   rob_entry_t entry_reg;
   rob_entry_t entry_next;

   always_comb begin
      entry_next = entry_reg;
      if (alloc_hit) begin
         entry_next.busy = 1'b1;
         entry_next.done = 1'b0;
         entry_next.dest = alloc_dest;
      end else if (entry_reg.busy) begin
         // Adder wins when both buses target this slot in the same cycle
         if (add_hit) begin
            entry_next.value = add_val;
            entry_next.done  = 1'b1;
         end else if (mul_hit) begin
            entry_next.value = mul_val;
            entry_next.done  = 1'b1;
         end
      end
      if (commit_hit) begin
         entry_next.busy = 1'b0;
         entry_next.done = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entry_reg <= '0;
      end else begin
         entry_reg <= entry_next;
      end
   end

   assign entry = entry_reg;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and retirement, out-of-order
// completion from two result buses, operand lookup by tag.
module reorder_buffer #(
   parameter int DEPTH  = ooo_pkg::DEPTH,
   parameter int TAG_W  = ooo_pkg::TAG_W,
   parameter int DATA_W = ooo_pkg::DATA_W,
   parameter int REG_W  = ooo_pkg::REG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              rob_full,
   output logic              rob_empty,
   input  logic              add_trigger,
   input  logic [DATA_W-1:0] add_val,
   input  logic [TAG_W-1:0]  add_tag,
   input  logic              mul_trigger,
   input  logic [DATA_W-1:0] mul_val,
   input  logic [TAG_W-1:0]  mul_tag,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_val,
   output logic              commit_valid,
   output logic [REG_W-1:0]  commit_reg,
   output logic [DATA_W-1:0] commit_val,
   output logic              bus_err
);

   localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W-1:0] LAST_TAG   = TAG_W'(DEPTH - 1);

   logic [TAG_W-1:0]    head_reg;
   logic [TAG_W-1:0]    tail_reg;
   logic [TAG_W:0]      count_reg;
   logic [TAG_W:0]      count_next;
   logic                commit_valid_reg;
   logic [REG_W-1:0]    commit_reg_reg;
   logic [DATA_W-1:0]   commit_val_reg;
   logic                bus_err_reg;
   ooo_pkg::rob_entry_t entry_reg [DEPTH];

   logic alloc_ok;
   logic commit_fire;
   logic add_err;
   logic mul_err;
   logic same_tag_err;

   assign rob_full    = (count_reg == FULL_COUNT);
   assign rob_empty   = (count_reg == '0);
   assign alloc_tag   = tail_reg;
   assign alloc_ok    = alloc_valid && !rob_full;
   assign commit_fire = entry_reg[head_reg].busy && entry_reg[head_reg].done;

   assign add_err      = add_trigger && !entry_reg[add_tag].busy;
   assign mul_err      = mul_trigger && !entry_reg[mul_tag].busy;
   assign same_tag_err = add_trigger && mul_trigger && (add_tag == mul_tag);

   assign rd_ready = entry_reg[rd_tag].busy && entry_reg[rd_tag].done;
   assign rd_val   = entry_reg[rd_tag].value;

   assign count_next = count_reg + {{TAG_W{1'b0}}, alloc_ok}
                                 - {{TAG_W{1'b0}}, commit_fire};

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      rob_entry u_entry (
         .clk        (clk),
         .reset      (reset),
         .alloc_hit  (alloc_ok && (tail_reg == TAG_W'(gi))),
         .alloc_dest (alloc_dest),
         .add_hit    (add_trigger && (add_tag == TAG_W'(gi))),
         .add_val    (add_val),
         .mul_hit    (mul_trigger && (mul_tag == TAG_W'(gi))),
         .mul_val    (mul_val),
         .commit_hit (commit_fire && (head_reg == TAG_W'(gi))),
         .entry      (entry_reg[gi])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         commit_valid_reg <= 1'b0;
         commit_reg_reg   <= '0;
         commit_val_reg   <= '0;
         bus_err_reg      <= 1'b0;
      end else begin
         if (alloc_ok) begin
            tail_reg <= (tail_reg == LAST_TAG) ? '0 : tail_reg + 1'b1;
         end
         if (commit_fire) begin
            head_reg       <= (head_reg == LAST_TAG) ? '0 : head_reg + 1'b1;
            commit_reg_reg <= entry_reg[head_reg].dest;
            commit_val_reg <= entry_reg[head_reg].value;
         end
         count_reg        <= count_next;
         commit_valid_reg <= commit_fire;
         bus_err_reg      <= add_err || mul_err || same_tag_err;
      end
   end

   assign commit_valid = commit_valid_reg;
   assign commit_reg   = commit_reg_reg;
   assign commit_val   = commit_val_reg;
   assign bus_err      = bus_err_reg;

endmodule
